// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: funct3 codes,
// FSM state encoding, default width and a two's complement negate helper.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NEG_W    = 128;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Wide enough for a 2*XLEN product at XLEN up to 64; callers size-cast the result.
  function automatic logic [NEG_W-1:0] negate(input logic [NEG_W-1:0] x);
    return ~x + {{(NEG_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iteration datapath: one shift-add multiply or restoring-divide step per step_i
// on a {hi, lo} register pair. The divide step exists only with MULDIV_DIV_EN.
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            is_div_i,
  input  logic [XLEN-1:0] lo_init_i,
  input  logic [XLEN-1:0] opnd_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN-1:0] hi_q, lo_q, opnd_q, hi_d, lo_d;
  logic [XLEN:0]   sum_s;
`ifdef MULDIV_DIV_EN
  logic [XLEN:0]   rem_sh_s, diff_s;
`endif

  // Next value of the register pair for the current operation class.
  always_comb begin
    sum_s = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
`ifdef MULDIV_DIV_EN
    rem_sh_s = {hi_q, lo_q[XLEN-1]};
    diff_s   = rem_sh_s - {1'b0, opnd_q};
    if (is_div_i) begin
      hi_d = diff_s[XLEN] ? rem_sh_s[XLEN-1:0] : diff_s[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], ~diff_s[XLEN]};
    end else begin
      hi_d = sum_s[XLEN:1];
      lo_d = {sum_s[0], lo_q[XLEN-1:1]};
    end
`else
    if (is_div_i) begin
      hi_d = hi_q;
      lo_d = lo_q;
    end else begin
      hi_d = sum_s[XLEN:1];
      lo_d = {sum_s[0], lo_q[XLEN-1:1]};
    end
`endif
  end

  // Register pair and latched multiplicand/divisor.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hi_q   <= {XLEN{1'b0}};
      lo_q   <= {XLEN{1'b0}};
      opnd_q <= {XLEN{1'b0}};
    end else if (load_i) begin
      hi_q   <= {XLEN{1'b0}};
      lo_q   <= lo_init_i;
      opnd_q <= opnd_i;
    end else if (step_i) begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer with fixed XLEN+3 cycle latency.
// Divide ops are implemented only when MULDIV_DIV_EN is defined; otherwise they return 0.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [2:0]        f3_q;
  logic              neg_q, busy_q, done_q;
  logic [XLEN-1:0]   fix_q, result_q;
  logic [XLEN-1:0]   hi_s, lo_s, mag_a_s, mag_b_s, mul_res_s, fix_d;
  logic [2*XLEN-1:0] prod_s, prod_fix_s;
  logic              accept_s, sa_s, sb_s, neg_s;
`ifdef MULDIV_DIV_EN
  logic [XLEN-1:0]   a_raw_q, div_raw_s, div_res_s;
  logic              div0_q, ovf_q;
`endif

  assign accept_s = (state_q == S_IDLE) && start_i && !flush_i;

  // Operand signedness, magnitudes and the sign the final result must carry.
  always_comb begin
    case (funct3_i)
      F3_MULH, F3_DIV, F3_REM: begin
        sa_s = op_a_i[XLEN-1];
        sb_s = op_b_i[XLEN-1];
      end
      F3_MULHSU: begin
        sa_s = op_a_i[XLEN-1];
        sb_s = 1'b0;
      end
      default: begin
        sa_s = 1'b0;
        sb_s = 1'b0;
      end
    endcase
    mag_a_s = sa_s ? XLEN'(negate(NEG_W'(op_a_i))) : op_a_i;
    mag_b_s = sb_s ? XLEN'(negate(NEG_W'(op_b_i))) : op_b_i;
    neg_s   = (funct3_i == F3_REM) ? sa_s : (sa_s ^ sb_s);
  end

  muldiv_core #(.XLEN(XLEN)) u_core (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (accept_s),
    .step_i    (state_q == S_CALC),
    .is_div_i  (f3_q[2]),
    .lo_init_i (funct3_i[2] ? mag_a_s : mag_b_s),
    .opnd_i    (funct3_i[2] ? mag_b_s : mag_a_s),
    .hi_o      (hi_s),
    .lo_o      (lo_s)
  );

  // Sign fix-up, half/quotient/remainder select and architectural overrides.
  always_comb begin
    prod_s     = {hi_s, lo_s};
    prod_fix_s = neg_q ? (2*XLEN)'(negate(NEG_W'(prod_s))) : prod_s;
    mul_res_s  = (f3_q == F3_MUL) ? prod_fix_s[XLEN-1:0] : prod_fix_s[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
    div_raw_s = f3_q[1] ? hi_s : lo_s;
    if (div0_q) begin
      div_res_s = f3_q[1] ? a_raw_q : {XLEN{1'b1}};
    end else if (ovf_q) begin
      div_res_s = f3_q[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
    end else begin
      div_res_s = neg_q ? XLEN'(negate(NEG_W'(div_raw_s))) : div_raw_s;
    end
    fix_d = f3_q[2] ? div_res_s : mul_res_s;
`else
    fix_d = f3_q[2] ? {XLEN{1'b0}} : mul_res_s;
`endif
  end

  // Control FSM; busy stays up through the done cycle so its width is XLEN+3.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CW{1'b0}};
      f3_q     <= 3'd0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fix_q    <= {XLEN{1'b0}};
      result_q <= {XLEN{1'b0}};
`ifdef MULDIV_DIV_EN
      a_raw_q  <= {XLEN{1'b0}};
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else if (flush_i && (state_q != S_IDLE)) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          busy_q <= accept_s;
          if (accept_s) begin
            state_q <= S_CALC;
            cnt_q   <= {CW{1'b0}};
            f3_q    <= funct3_i;
            neg_q   <= neg_s;
`ifdef MULDIV_DIV_EN
            a_raw_q <= op_a_i;
            div0_q  <= (op_b_i == {XLEN{1'b0}});
            ovf_q   <= !funct3_i[0] && (op_a_i == {1'b1, {(XLEN-1){1'b0}}})
                       && (op_b_i == {XLEN{1'b1}});
`endif
          end
        end
        S_CALC: begin
          cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_q == CNT_LAST) state_q <= S_FIX;
        end
        S_FIX: begin
          fix_q   <= fix_d;
          state_q <= S_DONE;
        end
        S_DONE: begin
          result_q <= fix_q;
          done_q   <= 1'b1;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign stall_o  = busy_q | (start_i & ~flush_i);
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed RV32M vectors, handshake
// corner cases and random ops against an arithmetic reference model.
module tb_muldiv_sequencer;

  localparam logic [2:0] M_MUL = 3'b000, M_MULH = 3'b001, M_MULHSU = 3'b010, M_MULHU = 3'b011;
  localparam logic [2:0] M_DIV = 3'b100, M_DIVU = 3'b101, M_REM = 3'b110, M_REMU = 3'b111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic        busy, stall, done;
  logic [31:0] result;

  int total = 0;
  int bad = 0;
  logic [31:0] last_exp = 32'd0;

  always #5 clk = ~clk;

  muldiv_sequencer dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .funct3_i(funct3),
    .op_a_i(op_a), .op_b_i(op_b), .flush_i(flush),
    .busy_o(busy), .stall_o(stall), .done_o(done), .result_o(result)
  );

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
`ifndef MULDIV_DIV_EN
    if (f[2]) return 32'd0;
`endif
    case (f)
      M_MUL:    begin p = sa * sb; return p[31:0];  end
      M_MULH:   begin p = sa * sb; return p[63:32]; end
      M_MULHSU: begin p = sa * ub; return p[63:32]; end
      M_MULHU:  begin p = ua * ub; return p[63:32]; end
      M_DIV:    begin if (b == 32'd0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      M_DIVU:   begin if (b == 32'd0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      M_REM:    begin if (b == 32'd0) return a; p = sa % sb; return p[31:0]; end
      M_REMU:   begin if (b == 32'd0) return a; p = ua % ub; return p[31:0]; end
      default:  return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one op from IDLE; optionally pulses a second start at cycle extra_k.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input int extra_k, input string tag);
    int busy_cnt, done_cnt, done_cyc;
    logic [31:0] exp;
    exp = ref_model(f, a, b);
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    busy_cnt = busy ? 1 : 0;
    done_cnt = 0;
    done_cyc = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (k == extra_k) begin
        funct3 = M_MULHU; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    chk({tag, ".result"}, result, exp);
    chk({tag, ".latency"}, 32'(done_cyc), 32'd34);
    chk({tag, ".busy_cycles"}, 32'(busy_cnt), 32'd35);
    chk({tag, ".done_count"}, 32'(done_cnt), 32'd1);
    last_exp = exp;
  endtask

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra, rb;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset.busy", {31'd0, busy}, 32'd0);
    chk("reset.done", {31'd0, done}, 32'd0);
    chk("reset.result", result, 32'd0);

    // stall is combinational from start/flush while idle
    start = 1'b1; flush = 1'b1;
    #1 chk("stall.flush", {31'd0, stall}, 32'd0);
    flush = 1'b0;
    #1 chk("stall.start", {31'd0, stall}, 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 chk("start_with_flush.busy", {31'd0, busy}, 32'd0);
    start = 1'b0; flush = 1'b0;

    do_op(M_MUL,    32'd7,         32'hFFFF_FFFD, 0, "mul");
    do_op(M_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu");
    do_op(M_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulh");
    do_op(M_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu");
    do_op(M_DIV,    32'hFFFF_FFF9, 32'd2,         0, "div");
    do_op(M_REM,    32'hFFFF_FFF9, 32'd2,         0, "rem");
    do_op(M_DIVU,   32'd100,       32'd7,         0, "divu");
    do_op(M_REMU,   32'd100,       32'd7,         0, "remu");
    do_op(M_DIVU,   32'd5,         32'd0,         0, "divu_by0");
    do_op(M_REM,    32'd5,         32'd0,         0, "rem_by0");
    do_op(M_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    do_op(M_REM,    32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");
    do_op(M_DIV,    32'd10,        32'd2,         0, "div_10_2");
    do_op(M_MUL,    32'd3,         32'd5,         5, "start_while_busy");

    // flush at cycle 10 of a MUL, then restart in the next cycle
    funct3 = M_MUL; op_a = 32'd9; op_b = 32'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush.busy", {31'd0, busy}, 32'd0);
    chk("flush.done", {31'd0, done}, 32'd0);
    chk("flush.result", result, last_exp);
    do_op(M_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 0, "after_flush");

    // random ops against the reference model
    for (int i = 0; i < 24; i++) begin
      rf = 3'($urandom_range(7, 0));
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 0) rb = 32'd0;
      if (i % 5 == 1) rb = 32'($urandom_range(15, 1));
      do_op(rf, ra, rb, 0, "random");
    end

    // reset at cycle 20 of a DIV
    funct3 = M_DIV; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_mid.busy", {31'd0, busy}, 32'd0);
    chk("rst_mid.done", {31'd0, done}, 32'd0);
    chk("rst_mid.result", result, 32'd0);
    do_op(M_REMU, 32'd77, 32'd10, 0, "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
